// File: rtl/etherneco_synctimer_pkg.sv
// etherneco_synctimer_pkg
// Shared definitions for the EtherNeco sync-timer slave front end:
//   - cmd_state_t : command-frame parser states
//   - CMD_BIT_*   : bit positions inside the command byte
//   - slot_base() : byte position of a node's offset/elapsed slot
package etherneco_synctimer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_TIME   = 3'd2,
    ST_SKIP   = 3'd3,
    ST_OFFSET = 3'd4,
    ST_DONE   = 3'd5
  } cmd_state_t;

  localparam int CMD_BIT_VALID    = 0;
  localparam int CMD_BIT_OVERRIDE = 1;

  // Slot base = header + time bytes + (node-1)*offset bytes, in 17 bits.
  // Node 0 yields a meaningless value; callers gate on node != 0.
  function automatic logic [16:0] slot_base(input int header_bytes,
                                            input int time_bytes,
                                            input int offset_bytes,
                                            input logic [7:0] node);
    logic [16:0] node_m1;
    node_m1 = {9'd0, node} - 17'd1;
    return 17'(header_bytes) + 17'(time_bytes) + node_m1 * 17'(offset_bytes);
  endfunction

endpackage

// File: rtl/etherneco_field_capture.sv
// etherneco_field_capture
// Captures an NBYTES little-endian field from a byte stream by position:
// byte i is taken when i_pos == i_base + i while i_enable and i_valid.
// Ports:
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_clear            : forget previous field (start of a new frame)
//   i_enable           : capture window open
//   i_base             : stream position of byte 0 of the field
//   i_pos/i_data/i_valid : byte stream
//   o_value            : captured field
//   o_done             : every byte of the field has been captured
//   o_done_next        : o_done as it will be after this cycle
module etherneco_field_capture #(
  parameter int NBYTES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [16:0]           i_base,
  input  logic [15:0]           i_pos,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic [8*NBYTES-1:0]   o_value,
  output logic                  o_done,
  output logic                  o_done_next
);

  logic [NBYTES-1:0]   r_mask;
  logic [NBYTES-1:0]   w_hit;
  logic [NBYTES-1:0]   w_mask_next;
  logic [8*NBYTES-1:0] r_value;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i_enable && i_valid && ({1'b0, i_pos} == i_base + 17'(i))) begin
        w_hit[i] = 1'b1;
      end
    end
    // Completeness is tracked per byte, so bytes may arrive in any order.
    w_mask_next = (i_clear ? '0 : r_mask) | w_hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask  <= '0;
      r_value <= '0;
    end else begin
      r_mask <= w_mask_next;
      for (int i = 0; i < NBYTES; i++) begin
        if (w_hit[i]) begin
          r_value[8*i +: 8] <= i_data;
        end else if (i_clear) begin
          r_value[8*i +: 8] <= 8'd0;
        end
      end
    end
  end

  assign o_value     = r_value;
  assign o_done      = &r_mask;
  assign o_done_next = &w_mask_next;

endmodule

// File: rtl/etherneco_synctimer_slave_ex.sv
// etherneco_synctimer_slave_ex
// Sync-timer slave front end: parses the command frame (cmd byte, master
// time, own offset slot), issues a one-shot correction request on a
// complete frame, measures command-to-response turnaround against a
// free-running counter, and writes that turnaround into the node's slot
// of the response frame.
// Ports:
//   clk, reset (async, active low), adj_enable
//   cmd_rx_*  : command frame start/end/error pulses and node index
//   s_cmd_*   : command byte stream
//   res_rx_*  : response frame start/error pulses
//   s_res_*   : response byte stream
//   m_res_*   : replacement response byte (one cycle after the match)
//   correct_* : correction request to the synctimer core
//   elapsed_* : last turnaround measurement
//   err_count : saturating count of rejected command frames
//   o_dbg_state : parser state
module etherneco_synctimer_slave_ex
  import etherneco_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH    = 64,
  parameter int TIME_BYTES     = 8,
  parameter int OFFSET_BYTES   = 4,
  parameter int HEADER_BYTES   = 1,
  parameter int FREE_RUN_STEP  = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adj_enable,
  input  logic                      cmd_rx_start,
  input  logic                      cmd_rx_end,
  input  logic                      cmd_rx_error,
  input  logic [7:0]                cmd_rx_node,
  input  logic                      s_cmd_first,
  input  logic [15:0]               s_cmd_pos,
  input  logic [7:0]                s_cmd_data,
  input  logic                      s_cmd_valid,
  input  logic                      res_rx_start,
  input  logic                      res_rx_error,
  input  logic [15:0]               s_res_pos,
  input  logic [7:0]                s_res_data,
  input  logic                      s_res_valid,
  output logic [7:0]                m_res_data,
  output logic                      m_res_valid,
  output logic [TIMER_WIDTH-1:0]    correct_time,
  output logic                      correct_override,
  output logic                      correct_valid,
  output logic [8*OFFSET_BYTES-1:0] elapsed_time,
  output logic                      elapsed_ok,
  output logic [15:0]               err_count,
  output logic [2:0]                o_dbg_state
);

  localparam int OW    = 8 * OFFSET_BYTES;
  localparam int TBW   = 8 * TIME_BYTES;
  localparam int SUM_W = (TIMER_WIDTH > OW) ? TIMER_WIDTH : OW;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  cmd_state_t       r_state;
  cmd_state_t       w_state_next;
  logic [7:0]       r_cmd;
  logic [16:0]      w_base;
  logic             w_node_ok;
  logic             w_first;
  logic             w_accept;
  logic [TBW-1:0]   w_time_val;
  logic             w_time_done;
  logic             w_time_done_next;
  logic [OW-1:0]    w_off_val;
  logic             w_off_done;
  logic             w_off_done_next;
  logic [SUM_W-1:0] w_sum;

  assign w_base    = slot_base(HEADER_BYTES, TIME_BYTES, OFFSET_BYTES, cmd_rx_node);
  assign w_node_ok = |cmd_rx_node;
  assign w_first   = s_cmd_valid && s_cmd_first;

  etherneco_field_capture #(.NBYTES(TIME_BYTES)) u_time_cap (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_clear     (w_first),
    .i_enable    ((r_state == ST_CMD) || (r_state == ST_TIME)),
    .i_base      (17'(HEADER_BYTES)),
    .i_pos       (s_cmd_pos),
    .i_data      (s_cmd_data),
    .i_valid     (s_cmd_valid),
    .o_value     (w_time_val),
    .o_done      (w_time_done),
    .o_done_next (w_time_done_next)
  );

  // Enabled from SKIP so the byte that matches the slot base is not lost.
  etherneco_field_capture #(.NBYTES(OFFSET_BYTES)) u_off_cap (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_clear     (w_first),
    .i_enable    (w_node_ok && ((r_state == ST_SKIP) || (r_state == ST_OFFSET))),
    .i_base      (w_base),
    .i_pos       (s_cmd_pos),
    .i_data      (s_cmd_data),
    .i_valid     (s_cmd_valid),
    .o_value     (w_off_val),
    .o_done      (w_off_done),
    .o_done_next (w_off_done_next)
  );

  // Parser next state. Frame end/error win over everything, then a
  // restart on s_cmd_first, then normal byte-driven progress.
  always_comb begin
    w_state_next = r_state;
    if (cmd_rx_error || cmd_rx_end) begin
      w_state_next = ST_IDLE;
    end else if (w_first) begin
      w_state_next = ST_CMD;
    end else if (s_cmd_valid) begin
      case (r_state)
        ST_CMD:  w_state_next = w_time_done_next ? ST_SKIP : ST_TIME;
        ST_TIME: if (w_time_done_next) w_state_next = ST_SKIP;
        ST_SKIP, ST_OFFSET: begin
          if (w_off_done_next) begin
            w_state_next = ST_DONE;
          end else if ((r_state == ST_SKIP) && w_node_ok && ({1'b0, s_cmd_pos} == w_base)) begin
            w_state_next = ST_OFFSET;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_accept = cmd_rx_end && !cmd_rx_error && (r_state == ST_DONE) &&
                    w_node_ok && w_time_done && w_off_done;
  assign w_sum    = SUM_W'(w_time_val) + SUM_W'(w_off_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_cmd            <= 8'd0;
      correct_time     <= '0;
      correct_override <= 1'b0;
      correct_valid    <= 1'b0;
      err_count        <= 16'd0;
    end else begin
      r_state       <= w_state_next;
      correct_valid <= 1'b0;
      if (w_first) begin
        r_cmd <= s_cmd_data;
      end
      if (w_accept) begin
        correct_time     <= w_sum[TIMER_WIDTH-1:0];
        correct_override <= r_cmd[CMD_BIT_OVERRIDE];
        correct_valid    <= r_cmd[CMD_BIT_VALID] && adj_enable;
      end else if (cmd_rx_end && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  // Turnaround measurement.
  logic [OW-1:0]   r_free;
  logic [OW-1:0]   r_stamp;
  logic            r_armed;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_expire;

  assign w_expire = r_armed && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free       <= '0;
      r_stamp      <= '0;
      r_armed      <= 1'b0;
      r_to_cnt     <= '0;
      elapsed_time <= '0;
      elapsed_ok   <= 1'b0;
    end else begin
      r_free <= r_free + OW'(FREE_RUN_STEP);
      if (res_rx_start && r_armed) begin
        elapsed_time <= r_free - r_stamp;
        elapsed_ok   <= 1'b1;
        r_armed      <= 1'b0;
      end else if (w_expire) begin
        elapsed_time <= '1;
        elapsed_ok   <= 1'b0;
        r_armed      <= 1'b0;
      end else if (r_armed) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      // Placed last so a simultaneous start re-arms after measuring.
      if (cmd_rx_start) begin
        r_stamp  <= r_free;
        r_armed  <= 1'b1;
        r_to_cnt <= '0;
      end
    end
  end

  // Response insertion.
  logic       r_res_sup;
  logic       w_ins_hit;
  logic [7:0] w_ins_byte;

  always_comb begin
    w_ins_hit  = 1'b0;
    w_ins_byte = 8'd0;
    if (s_res_valid && w_node_ok && !r_res_sup && !res_rx_error) begin
      for (int i = 0; i < OFFSET_BYTES; i++) begin
        if ({1'b0, s_res_pos} == w_base + 17'(i)) begin
          w_ins_hit  = 1'b1;
          w_ins_byte = elapsed_time[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_sup   <= 1'b0;
      m_res_valid <= 1'b0;
      m_res_data  <= 8'd0;
    end else begin
      if (res_rx_error) begin
        r_res_sup <= 1'b1;
      end else if (res_rx_start) begin
        r_res_sup <= 1'b0;
      end
      m_res_valid <= w_ins_hit;
      m_res_data  <= w_ins_byte;
    end
  end

  assign o_dbg_state = r_state;

endmodule
